// File: rtl/four_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux, with a burst limit that forces rotation.
// Optional macro FOUR_MUX_ARB_LOCK_EN adds a lock input that suppresses burst rotation.
//
// state | meaning
// IDLE  | no owner, gnt=0
// BUSY  | one owner, {s1,s0} = owner index
module four_mux_arbiter #(
    parameter int MAXBURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
`ifdef FOUR_MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       w,
    output logic       valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] owner;
    logic [3:0] data;
    logic [3:0] cand;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    logic       lock_hold;
    logic       hold;

    assign owner = {s1, s0};
    assign data  = {d, c, b, a};

`ifdef FOUR_MUX_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // The current owner is never a candidate, so "found" also means "another source waits".
    always_comb begin
        cand = req;
        if (state == BUSY) begin
            cand[owner] = 1'b0;
        end
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign hold = (state == BUSY) && req[owner] &&
                  ((cnt < 4'(MAXBURST)) || !found || lock_hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            gnt   <= 4'b0000;
            s1    <= 1'b0;
            s0    <= 1'b0;
            w     <= 1'b0;
            valid <= 1'b0;
        end else begin
            // Datapath follows the owner of the previous cycle, hence one cycle behind gnt.
            valid <= (state == BUSY);
            w     <= (state == BUSY) ? data[owner] : 1'b0;

            if (hold) begin
                if (cnt < 4'(MAXBURST)) begin
                    cnt <= cnt + 4'd1;
                end
            end else if (found) begin
                state    <= BUSY;
                gnt      <= 4'b0001 << win;
                {s1, s0} <= win;
                cnt      <= 4'd1;
                ptr      <= win + 2'd1;
            end else begin
                state    <= IDLE;
                gnt      <= 4'b0000;
                {s1, s0} <= 2'b00;
                cnt      <= 4'd0;
            end
        end
    end

endmodule

// File: doc/four_mux_arbiter.md
FOUR_MUX_ARBITER -- requirements
Module: four_mux_arbiter

Interface
REQ-001 Parameter: MAXBURST, default 4, max consecutive grant cycles before forced rotation when others wait; legal 1..15.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-005 a, b, c, d  input  1 each  data inputs of the shared 4:1 mux datapath.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-007 s1, s0  output  1 each  registered mux select, {s1,s0} = index of current owner.
REQ-008 w  output  1  registered mux output of the owner's data input.
REQ-009 valid  output  1  high exactly while a grant is active; qualifies w.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and BUSY (one owner).
REQ-011 The block SHALL keep a 2-bit round-robin pointer ptr and a 4-bit burst counter cnt.
REQ-012 Arbitration SHALL pick the first asserted req index scanning ptr, ptr+1, ... mod 4.
REQ-013 IDLE: any req high -> BUSY next edge, gnt/{s1,s0} = winner, cnt=1; else stay IDLE.
REQ-014 BUSY, req[owner]=0: re-arbitrate same edge among other reqs; winner -> new owner, cnt=1; none -> IDLE, gnt=0.
REQ-015 BUSY, req[owner]=1, cnt<MAXBURST: keep owner, cnt increments.
REQ-016 BUSY, req[owner]=1, cnt=MAXBURST, another req pending: rotate to next winner from owner+1, cnt=1.
REQ-017 BUSY, req[owner]=1, cnt=MAXBURST, no other req: keep owner, cnt saturates at MAXBURST.
REQ-018 On every new grant ptr SHALL become winner+1 mod 4 (wraps 3 -> 0).
REQ-019 Grant latency SHALL be one cycle: req sampled at edge N, gnt valid after edge N.
REQ-020 w SHALL update each edge to data[{s1,s0}] as sampled that edge while valid=1; w=0 and valid=0 while IDLE.
REQ-021 w therefore lags gnt by one cycle; after a handover, first w of new owner appears one cycle after its gnt.
REQ-022 gnt SHALL never have more than one bit set; no idle gap SHALL occur on direct handover.
REQ-023 Simultaneous req changes and release in the same cycle SHALL follow REQ-014 using req values at that edge.

Reset
REQ-024 rst=1 SHALL immediately force gnt=0000, s1=0, s0=0, w=0, valid=0, state=IDLE, ptr=0, cnt=0.
REQ-025 Reset asserted mid-grant SHALL drop the grant without completing the burst; first arbitration after release starts from ptr=0.
REQ-026 First arbitration SHALL occur on the first rising edge with rst=0.

Configuration
REQ-027 Macro FOUR_MUX_ARB_LOCK_EN SHALL, when defined, add input port lock (1 bit).
REQ-028 With FOUR_MUX_ARB_LOCK_EN: lock=1 while req[owner]=1 disables REQ-016 rotation (owner keeps grant, cnt saturates); lock ignored in IDLE.
REQ-029 Without FOUR_MUX_ARB_LOCK_EN: no lock port; burst limit always enforced.

Verification
REQ-030 rst pulse mid-burst (owner b) -> all outputs zero immediately; next req=0001 grants a, s1s0=00.
REQ-031 req=0001, a=1, MAXBURST=4 -> gnt=0001 after 1 edge, w=1 valid one edge later, grant held indefinitely.
REQ-032 req=1111 held -> grants a,b,c,d,a each 4 cycles, s1s0 00,01,10,11,00 (wrap checked).
REQ-033 owner c drops req while req=1011 -> next edge gnt=1000 (d), no idle cycle; then d drops -> gnt=0001.
REQ-034 req=0101 from reset, d data toggling ignored -> w tracks a then c only, gnt never multi-hot.
REQ-035 LOCK_EN build, owner a, lock=1, req=0011 for 10 cycles -> gnt stays 0001; lock=0 -> gnt=0010 next edge.
